// File: rtl/pace_param_bank.sv
`default_nettype none
// ============================================================================
// Module      : pace_param_bank
// Description : Memory-mapped shadow parameter sets for the PACE evaluator.
//               A busy-gated commit copies one set into the active parameter register.
// Revision    : 1.0 - initial release
// ============================================================================
module pace_param_bank #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 16,
  parameter int NumSets       = 2,
  parameter int PaceDegree    = 2,
  parameter int PaceParts     = 16,
  parameter int PaceEps       = 1,
  parameter int PaceDataWidth = 32,
  localparam int ParamWidth   = (PaceDegree + 1) * PaceParts * PaceDataWidth
                              + (PaceParts - 1) * PaceDataWidth
                              + 2 * PaceDataWidth * PaceEps,
  localparam int WordsPerSet  = (ParamWidth + DataWidth - 1) / DataWidth,
  localparam int SetAddrWidth = $clog2(WordsPerSet),
  localparam int AddrOffset   = $clog2(DataWidth / 8),
  localparam int SetIdxWidth  = (NumSets > 1) ? $clog2(NumSets) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic                   mem_we_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   mem_err_o,
  input  logic                   commit_valid_i,
  input  logic [SetIdxWidth-1:0] commit_set_i,
  output logic                   commit_ready_o,
  input  logic                   pace_busy_i,
  output logic [SetIdxWidth-1:0] active_set_o,
  output logic [ParamWidth-1:0]  pace_param_o
);

  localparam int c_set_bits  = $clog2(NumSets);
  localparam int c_upper_lsb = AddrOffset + SetAddrWidth + c_set_bits;
  localparam int c_strb_w    = DataWidth / 8;
  localparam int c_flat_w    = WordsPerSet * DataWidth;

  localparam logic [SetAddrWidth:0] c_words    = (SetAddrWidth + 1)'(WordsPerSet);
  localparam logic [SetIdxWidth:0]  c_num_sets = (SetIdxWidth + 1)'(NumSets);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [SetAddrWidth-1:0] w_word;
  logic [SetIdxWidth-1:0]  w_set;
  logic                    w_upper_nz;
  logic                    w_in_range;
  logic                    w_wr_en;
  logic                    w_unused_addr;

  assign w_word        = mem_addr_i[AddrOffset +: SetAddrWidth];
  assign w_unused_addr = ^mem_addr_i[AddrOffset-1:0];

  generate
    if (c_set_bits > 0) begin : g_set_field
      assign w_set = mem_addr_i[AddrOffset + SetAddrWidth +: SetIdxWidth];
    end else begin : g_set_none
      assign w_set = '0;
    end

    if (c_upper_lsb < AddrWidth) begin : g_upper
      assign w_upper_nz = |mem_addr_i[AddrWidth-1:c_upper_lsb];
    end else begin : g_no_upper
      assign w_upper_nz = 1'b0;
    end
  endgenerate

  assign w_in_range = ({1'b0, w_word} < c_words)
                    & ({1'b0, w_set} < c_num_sets)
                    & ~w_upper_nz;
  assign w_wr_en    = mem_req_i & mem_we_i & w_in_range;

  // ---------------------------------------------------------------------------
  // Set storage: each set is one flat vector so a commit is a single row copy
  // ---------------------------------------------------------------------------
  logic [NumSets-1:0][c_flat_w-1:0] r_mem;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem <= '0;
    end else if (w_wr_en) begin
      for (int b = 0; b < c_strb_w; b++) begin
        if (mem_strb_i[b]) begin
          r_mem[w_set][w_word * DataWidth + 8 * b +: 8] <= mem_wdata_i[8 * b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory response
  // ---------------------------------------------------------------------------
  logic                 r_rvalid;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= mem_req_i;
      r_err    <= mem_req_i & ~w_in_range;
      if (mem_req_i & ~mem_we_i & w_in_range) begin
        r_rdata <= r_mem[w_set][w_word * DataWidth +: DataWidth];
      end else begin
        r_rdata <= '0;
      end
    end
  end

  assign mem_gnt_o    = 1'b1;
  assign mem_rvalid_o = r_rvalid;
  assign mem_rdata_o  = r_rdata;
  assign mem_err_o    = r_err;

  // ---------------------------------------------------------------------------
  // Commit: the copy reads the register contents before this edge, so a
  // same-cycle write to the committed set lands only in storage.
  // ---------------------------------------------------------------------------
  logic                   w_commit;
  logic [c_flat_w-1:0]    w_sel_flat;
  logic [ParamWidth-1:0]  r_param;
  logic [SetIdxWidth-1:0] r_active;

  assign w_commit   = commit_valid_i & ~pace_busy_i & ({1'b0, commit_set_i} < c_num_sets);
  assign w_sel_flat = r_mem[commit_set_i];

  generate
    if (c_flat_w > ParamWidth) begin : g_tail
      logic w_unused_tail;
      assign w_unused_tail = ^w_sel_flat[c_flat_w-1:ParamWidth];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_param  <= '0;
      r_active <= '0;
    end else if (w_commit) begin
      r_param  <= w_sel_flat[ParamWidth-1:0];
      r_active <= commit_set_i;
    end
  end

  assign commit_ready_o = w_commit;
  assign active_set_o   = r_active;
  assign pace_param_o   = r_param;

endmodule
`default_nettype wire

// File: tb/tb_pace_param_bank.sv
`default_nettype none
// Testbench for pace_param_bank: directed scenarios plus random traffic
// checked against an array-based reference model of the parameter bank.
module tb_pace_param_bank;

  localparam int DW  = 32;
  localparam int NS  = 2;
  localparam int PW  = 3 * 16 * 32 + 15 * 32 + 2 * 32;
  localparam int WPS = (PW + DW - 1) / DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_req = 1'b0;
  logic          mem_gnt;
  logic [15:0]   mem_addr = '0;
  logic          mem_we = 1'b0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_strb = '0;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          mem_err;
  logic          commit_valid = 1'b0;
  logic [0:0]    commit_set = '0;
  logic          commit_ready;
  logic          pace_busy = 1'b0;
  logic [0:0]    active_set;
  logic [PW-1:0] pace_param;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mem [NS][WPS];
  logic [31:0] m_param [WPS];
  int          m_active;

  always #5 clk = ~clk;

  pace_param_bank dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_req_i      (mem_req),
    .mem_gnt_o      (mem_gnt),
    .mem_addr_i     (mem_addr),
    .mem_we_i       (mem_we),
    .mem_wdata_i    (mem_wdata),
    .mem_strb_i     (mem_strb),
    .mem_rvalid_o   (mem_rvalid),
    .mem_rdata_o    (mem_rdata),
    .mem_err_o      (mem_err),
    .commit_valid_i (commit_valid),
    .commit_set_i   (commit_set),
    .commit_ready_o (commit_ready),
    .pace_busy_i    (pace_busy),
    .active_set_o   (active_set),
    .pace_param_o   (pace_param)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  function automatic int param_bad();
    int n = 0;
    for (int k = 0; k < WPS; k++)
      if (pace_param[k * DW +: DW] !== m_param[k]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < WPS; w++) m_mem[s][w] = '0;
    for (int k = 0; k < WPS; k++) m_param[k] = '0;
    m_active = 0;
  endtask

  // Byte address -> (set, word); anything beyond set/word fields is illegal
  function automatic void decode(input logic [15:0] a, output int s, output int w, output bit oor);
    w   = (int'(a) / 4) % 128;
    s   = (int'(a) / 512) % 2;
    oor = (w >= WPS) || (int'(a) >= 1024);
  endfunction

  task automatic check_outputs(input bit exp_rv, input logic [31:0] exp_rd, input bit exp_err);
    chk("rvalid", mem_rvalid, exp_rv);
    chk("rdata", mem_rdata, exp_rd);
    chk("err", mem_err, exp_err);
    chk("active_set", active_set, m_active);
    chk("param_bad_chunks", param_bad(), 0);
  endtask

  task automatic do_cycle(input bit req, input bit we, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input bit cv, input bit cs, input bit busy);
    int s, w;
    bit oor, exp_ready, exp_rv, exp_err;
    logic [31:0] exp_rd;
    mem_req = req; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_strb = strb;
    commit_valid = cv; commit_set = cs; pace_busy = busy;
    #1;
    chk("gnt", mem_gnt, 1'b1);
    exp_ready = cv && !busy && (int'(cs) < NS);
    chk("commit_ready", commit_ready, exp_ready);
    decode(addr, s, w, oor);
    exp_rv  = req;
    exp_err = req && oor;
    exp_rd  = (req && !we && !oor) ? m_mem[s][w] : 32'h0;
    if (exp_ready) begin
      for (int k = 0; k < WPS; k++) m_param[k] = m_mem[cs][k];
      m_active = int'(cs);
    end
    if (req && we && !oor)
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_mem[s][w][8 * b +: 8] = wdata[8 * b +: 8];
    @(posedge clk);
    #1;
    check_outputs(exp_rv, exp_rd, exp_err);
  endtask

  task automatic idle();
    do_cycle(0, 0, 16'h0, 32'h0, 4'h0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    bit          r_req, r_we, r_cv, r_cs, r_busy;
    int          rs, rw;
    logic [15:0] r_addr;

    model_reset();
    #1 rst = 1'b1;
    mem_req = 1'b1;
    #11;
    check_outputs(0, 32'h0, 0);
    #11 rst = 1'b0;
    mem_req = 1'b0;
    @(posedge clk);
    #1;
    check_outputs(0, 32'h0, 0);

    // Full-word write then read back
    do_cycle(1, 1, 16'h000, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_cycle(1, 0, 16'h000, 32'h0, 4'h0, 0, 0, 0);
    chk("rd_deadbeef", mem_rdata, 32'hDEADBEEF);

    // Partial strobes on set1 word1; set0 word1 untouched
    do_cycle(1, 1, 16'h204, 32'h11223344, 4'h5, 0, 0, 0);
    do_cycle(1, 0, 16'h204, 32'h0, 4'h0, 0, 0, 0);
    chk("rd_strb5", mem_rdata, 32'h00220044);
    do_cycle(1, 0, 16'h004, 32'h0, 4'h0, 0, 0, 0);
    chk("rd_set0_w1", mem_rdata, 32'h0);

    // Out-of-range word 65 and the last legal word 64
    do_cycle(1, 0, 16'h104, 32'h0, 4'h0, 0, 0, 0);
    chk("oor_err", mem_err, 1'b1);
    do_cycle(1, 1, 16'h104, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_cycle(1, 1, 16'h100, 32'h0BADCAFE, 4'hF, 0, 0, 0);
    do_cycle(1, 0, 16'h100, 32'h0, 4'h0, 0, 0, 0);
    chk("rd_last_word", mem_rdata, 32'h0BADCAFE);
    do_cycle(1, 0, 16'h400, 32'h0, 4'h0, 0, 0, 0);
    chk("upper_bit_err", mem_err, 1'b1);

    // Commit held off by busy, accepted as soon as busy drops
    do_cycle(1, 1, 16'h200, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    do_cycle(0, 0, 16'h0, 32'h0, 4'h0, 1, 1, 1);
    do_cycle(0, 0, 16'h0, 32'h0, 4'h0, 1, 1, 1);
    chk("busy_active", active_set, 1'b0);
    do_cycle(0, 0, 16'h0, 32'h0, 4'h0, 1, 1, 0);
    chk("commit_param0", pace_param[31:0], 32'hA5A5A5A5);
    chk("commit_active", active_set, 1'b1);

    // Same-cycle write to the committed set: copy sees the old word
    do_cycle(1, 1, 16'h200, 32'h00000001, 4'hF, 1, 1, 0);
    chk("wr_commit_param0", pace_param[31:0], 32'hA5A5A5A5);
    do_cycle(1, 0, 16'h200, 32'h0, 4'h0, 0, 0, 0);
    chk("wr_commit_stored", mem_rdata, 32'h00000001);

    // Writes to the active set never leak into the parameter output
    do_cycle(1, 1, 16'h208, 32'h12345678, 4'hF, 0, 0, 0);
    chk("no_leak_w2", pace_param[95:64], 32'h0);

    for (int i = 0; i < 400; i++) begin
      r_req  = ($urandom_range(0, 3) != 0);
      r_we   = ($urandom_range(0, 1) != 0);
      rs     = int'($urandom_range(0, 1));
      rw     = int'($urandom_range(0, 64));
      r_addr = 16'(rs * 512 + rw * 4 + int'($urandom_range(0, 3)));
      case ($urandom_range(0, 9))
        0: r_addr = 16'(rs * 512 + int'($urandom_range(65, 127)) * 4);
        1: r_addr = r_addr | 16'(1 << $urandom_range(10, 15));
        default: ;
      endcase
      r_cv   = ($urandom_range(0, 4) == 0);
      r_cs   = ($urandom_range(0, 1) != 0);
      r_busy = ($urandom_range(0, 2) == 0);
      do_cycle(r_req, r_we, r_addr, $urandom, 4'($urandom_range(0, 15)), r_cv, r_cs, r_busy);
    end

    for (int s = 0; s < NS; s++)
      for (int w = 0; w < WPS; w++)
        do_cycle(1, 0, 16'(s * 512 + w * 4), 32'h0, 4'h0, 0, 0, 0);

    // Commit set1 so active/param are non-zero, then reset mid-request
    do_cycle(1, 1, 16'h200, 32'h5A5A5A5A, 4'hF, 1, 1, 0);
    do_cycle(1, 0, 16'h200, 32'h0, 4'h0, 1, 1, 0);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h200; mem_wdata = 32'hFFFFFFFF; mem_strb = 4'hF;
    commit_valid = 1'b0; pace_busy = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs(0, 32'h0, 0);
    @(posedge clk);
    #1;
    check_outputs(0, 32'h0, 0);
    #2 rst = 1'b0;
    do_cycle(1, 0, 16'h200, 32'h0, 4'h0, 0, 0, 0);
    chk("post_reset_rd", mem_rdata, 32'h0);
    do_cycle(1, 0, 16'h000, 32'h0, 4'h0, 0, 0, 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
